freq_meter_scheduler: RTL and testbench



---
 rtl/freq_meter_pkg.sv | 21 ++
 rtl/freq_gate_counter.sv | 60 ++++++
 rtl/freq_meter_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_freq_meter_scheduler.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared state type and constants for the multi-channel frequency meter.
// Used by freq_meter_scheduler and freq_gate_counter.
package freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_GATE   = 2'd2,
      ST_LATCH  = 2'd3
   } fm_state_e;

   localparam int SETTLE_CYCLES   = 2;
   localparam int GATE_CYCLES_DEF = 50_000_000;
   localparam int SCALE_SHIFT_DEF = 1;

   // Widest edge count a gate can produce: one rising edge every two cycles.
   function automatic int cnt_width(input int gate_cycles);
      return $clog2(gate_cycles / 2 + 1);
   endfunction

endpackage

// File: rtl/freq_gate_counter.sv
// Rising-edge detector feeding a saturating clear/enable edge counter.
// Optional FREQ_SCHED_OVF_EN adds a sticky saturation flag (sat_o).
module freq_gate_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sample_i,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] count_o
`ifdef FREQ_SCHED_OVF_EN
   ,
   output logic             sat_o
`endif
);

   logic             prev_q;
   logic [CNT_W-1:0] count_q;
   logic             rise;
   logic             at_max;

   assign rise   = sample_i & ~prev_q;
   assign at_max = (count_q == '1);

   // History always follows the selected sample, so a level already present
   // when the gate opens never looks like a fresh edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q  <= 1'b0;
         count_q <= '0;
      end else begin
         prev_q <= sample_i;
         if (clr_i) begin
            count_q <= '0;
         end else if (en_i && rise && !at_max) begin
            count_q <= count_q + 1'b1;
         end
      end
   end

   assign count_o = count_q;

`ifdef FREQ_SCHED_OVF_EN
   logic sat_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sat_q <= 1'b0;
      end else if (clr_i) begin
         sat_q <= 1'b0;
      end else if (en_i && rise && at_max) begin
         sat_q <= 1'b1;
      end
   end

   assign sat_o = sat_q;
`endif

endmodule

// File: rtl/freq_meter_scheduler.sv
// Time-multiplexed frequency meter: walks the masked channels through one gated edge counter.
// Optional FREQ_SCHED_OVF_EN adds the ovf output (count saturated during the reported gate).
//
// state  | meaning
// IDLE   | waiting for start/continuous with a non-zero channel mask
// SETTLE | 2 cycles after a channel switch; mux output settles, nothing counted
// GATE   | GATE_CYCLES cycles counting rising edges of the selected channel
// LATCH  | publish count << SCALE_SHIFT, pick next channel or end the sweep
module freq_meter_scheduler
   import freq_meter_pkg::*;
#(
   parameter  int NUM_CH      = 4,
   parameter  int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter  int SCALE_SHIFT = SCALE_SHIFT_DEF,
   parameter  int CNT_W       = cnt_width(GATE_CYCLES),
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int FREQ_W      = CNT_W + SCALE_SHIFT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] waveform,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              start,
   input  logic              continuous,
   output logic              busy,
   output logic              result_valid,
   output logic [CH_W-1:0]   result_ch,
   output logic [FREQ_W-1:0] result_freq,
   output logic              sweep_done
`ifdef FREQ_SCHED_OVF_EN
   ,
   output logic              ovf
`endif
);

   localparam int               GATE_W      = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GATE_W-1:0] GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);
   localparam logic [1:0]        SETTLE_LOAD = 2'(SETTLE_CYCLES - 1);

   fm_state_e         state_q;
   logic [NUM_CH-1:0] mask_q;
   logic [CH_W-1:0]   ch_q;
   logic [1:0]        settle_q;
   logic [GATE_W-1:0] gate_q;
   logic              busy_q;
   logic              result_valid_q;
   logic              sweep_done_q;
   logic [CH_W-1:0]   result_ch_q;
   logic [FREQ_W-1:0] result_freq_q;

   logic [NUM_CH-1:0] sync1_q;
   logic [NUM_CH-1:0] sync2_q;

   logic [CH_W-1:0]   first_ch_d;
   logic [CH_W-1:0]   next_ch_d;
   logic              has_next_d;
   logic              launch;

   logic              sel_sample;
   logic              cnt_en;
   logic              cnt_clr;
   logic [CNT_W-1:0]  count;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= waveform;
         sync2_q <= sync1_q;
      end
   end

   assign sel_sample = sync2_q[ch_q];

   // Lowest set bit of the live mask (sweep start) and of the held mask above ch_q.
   always_comb begin
      first_ch_d = '0;
      next_ch_d  = '0;
      has_next_d = 1'b0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (ch_mask[i]) begin
            first_ch_d = CH_W'(i);
         end
         if (mask_q[i] && (CH_W'(i) > ch_q)) begin
            next_ch_d  = CH_W'(i);
            has_next_d = 1'b1;
         end
      end
   end

   assign launch = (ch_mask != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         mask_q         <= '0;
         ch_q           <= '0;
         settle_q       <= '0;
         gate_q         <= '0;
         busy_q         <= 1'b0;
         result_valid_q <= 1'b0;
         sweep_done_q   <= 1'b0;
         result_ch_q    <= '0;
         result_freq_q  <= '0;
      end else begin
         result_valid_q <= 1'b0;
         sweep_done_q   <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if ((start || continuous) && launch) begin
                  mask_q   <= ch_mask;
                  ch_q     <= first_ch_d;
                  settle_q <= SETTLE_LOAD;
                  busy_q   <= 1'b1;
                  state_q  <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_q == '0) begin
                  gate_q  <= GATE_LOAD;
                  state_q <= ST_GATE;
               end else begin
                  settle_q <= settle_q - 1'b1;
               end
            end
            ST_GATE: begin
               if (gate_q == '0) begin
                  state_q <= ST_LATCH;
               end else begin
                  gate_q <= gate_q - 1'b1;
               end
            end
            ST_LATCH: begin
               result_valid_q <= 1'b1;
               result_ch_q    <= ch_q;
               result_freq_q  <= FREQ_W'(count) << SCALE_SHIFT;
               settle_q       <= SETTLE_LOAD;
               if (has_next_d) begin
                  ch_q    <= next_ch_d;
                  state_q <= ST_SETTLE;
               end else begin
                  sweep_done_q <= 1'b1;
                  if (continuous && launch) begin
                     mask_q  <= ch_mask;
                     ch_q    <= first_ch_d;
                     state_q <= ST_SETTLE;
                  end else begin
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cnt_en  = (state_q == ST_GATE);
   assign cnt_clr = (state_q == ST_LATCH) || (state_q == ST_IDLE);

`ifdef FREQ_SCHED_OVF_EN
   logic sat;
   logic ovf_q;

   freq_gate_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .sample_i (sel_sample),
      .en_i     (cnt_en),
      .clr_i    (cnt_clr),
      .count_o  (count),
      .sat_o    (sat)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (state_q == ST_LATCH) begin
         ovf_q <= sat;
      end
   end

   assign ovf = ovf_q;
`else
   freq_gate_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .sample_i (sel_sample),
      .en_i     (cnt_en),
      .clr_i    (cnt_clr),
      .count_o  (count)
   );
`endif

   assign busy         = busy_q;
   assign result_valid = result_valid_q;
   assign result_ch    = result_ch_q;
   assign result_freq  = result_freq_q;
   assign sweep_done   = sweep_done_q;

endmodule

// File: tb/tb_freq_meter_scheduler.sv
// Bench for freq_meter_scheduler: constant vector table, hand sequences, and
// randomized sweeps scored against an edge-counting reference model.
`timescale 1ns/1ps
module tb_freq_meter_scheduler;

   localparam int G      = 1000;
   localparam int G2     = 40;
   localparam int CMAX   = 511;
   localparam int HIST_N = 65536;

   logic       clk = 1'b0;
   logic       reset, start, continuous;
   logic [3:0] waveform, ch_mask;

   logic       busy, rv, sd;
   logic [1:0] rch;
   logic [9:0] rfreq;
   logic       busy2, rv2, sd2;
   logic [1:0] rch2;
   logic [4:0] rfreq2;
`ifdef FREQ_SCHED_OVF_EN
   logic       ovf, ovf2;
`endif

   freq_meter_scheduler #(.NUM_CH(4), .GATE_CYCLES(G), .SCALE_SHIFT(1)) dut (
      .clk(clk), .reset(reset), .waveform(waveform), .ch_mask(ch_mask),
      .start(start), .continuous(continuous), .busy(busy),
      .result_valid(rv), .result_ch(rch), .result_freq(rfreq), .sweep_done(sd)
`ifdef FREQ_SCHED_OVF_EN
      , .ovf(ovf)
`endif
   );

   freq_meter_scheduler #(.NUM_CH(4), .GATE_CYCLES(G2), .SCALE_SHIFT(1), .CNT_W(4)) dut2 (
      .clk(clk), .reset(reset), .waveform(waveform), .ch_mask(ch_mask),
      .start(start), .continuous(continuous), .busy(busy2),
      .result_valid(rv2), .result_ch(rch2), .result_freq(rfreq2), .sweep_done(sd2)
`ifdef FREQ_SCHED_OVF_EN
      , .ovf(ovf2)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Channel c is a square wave with half-period hp[c]; every driven value is logged per cycle.
   int         hp [4] = '{5, 10, 2, 4};
   logic [3:0] hist [0:HIST_N-1];

   always @(negedge clk) begin : wave_gen
      logic [3:0] w;
      for (int c = 0; c < 4; c++) w[c] = ((cyc / hp[c]) % 2) == 1;
      waveform = w;
      if (cyc < HIST_N) hist[cyc] = w;
   end

   typedef struct {
      int cy;
      int ch;
      int fq;
      bit dn;
   } res_t;

   res_t got_q[$];
   res_t exp_q[$];

   always @(negedge clk) begin : monitor
      res_t r;
      if (rv === 1'b1) begin
         r.cy = cyc;
         r.ch = int'(rch);
         r.fq = int'(rfreq);
         r.dn = (sd === 1'b1);
         got_q.push_back(r);
      end
   end

   typedef struct packed {
      logic [3:0]        mask;
      logic [3:0][7:0]   hp;
      logic [3:0][11:0]  fq;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] expv);
      total++;
      if (got !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, got, expv);
      end
   endtask

   // Rising edges seen by the meter in gate cycles gs..gs+len-1: two-flop delay, then 0->1.
   function automatic int rises(input int gs, input int len, input int ch);
      int n;
      n = 0;
      for (int c = gs; c < gs + len; c++)
         if (hist[c-2][ch] === 1'b1 && hist[c-3][ch] === 1'b0) n++;
      return n;
   endfunction

   // One sweep whose first SETTLE cycle is s: 2 settle, G gate, 1 latch per channel.
   task automatic model_sweep(input int s, input logic [3:0] mask, output int next_s);
      int   idx, last, gs, n;
      res_t r;
      idx    = 0;
      last   = -1;
      next_s = s;
      for (int c = 0; c < 4; c++) if (mask[c]) last = c;
      for (int c = 0; c < 4; c++) begin
         if (mask[c]) begin
            gs = s + idx * (G + 3) + 2;
            n  = rises(gs, G, c);
            if (n > CMAX) n = CMAX;
            r.cy = gs + G + 1;
            r.ch = c;
            r.fq = n * 2;
            r.dn = (c == last);
            exp_q.push_back(r);
            next_s = gs + G + 1;
            idx++;
         end
      end
   endtask

   task automatic compare_q(input string nm);
      chk($sformatf("%s_nres", nm), 64'(got_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s_cyc%0d", nm, i), 64'(got_q[i].cy), 64'(exp_q[i].cy));
         chk($sformatf("%s_ch%0d", nm, i), 64'(got_q[i].ch), 64'(exp_q[i].ch));
         chk($sformatf("%s_freq%0d", nm, i), 64'(got_q[i].fq), 64'(exp_q[i].fq));
         chk($sformatf("%s_done%0d", nm, i), 64'(got_q[i].dn), 64'(exp_q[i].dn));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic pulse_start(output int k);
      start = 1'b1;
      k     = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (busy !== 1'b0) begin
         total++;
         bad++;
         $display("FAIL %s_timeout: busy=%b after %0d cycles, expected 0", nm, busy, budget);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_rv2(input int budget);
      int n;
      n = 0;
      while (rv2 !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin : watchdog
      #900_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total + 1, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int         k, k2, s2, s3, ns, n, idx, lastfq;
      bit         seen, dropped;
      logic [3:0] m;

      vecs[0].mask = 4'b0001; vecs[0].hp = {8'd4,  8'd2, 8'd10, 8'd5};
      vecs[0].fq   = {12'd0,   12'd0,   12'd0,   12'd200};
      vecs[1].mask = 4'b1010; vecs[1].hp = {8'd2,  8'd2, 8'd10, 8'd5};
      vecs[1].fq   = {12'd500, 12'd0,   12'd100, 12'd0};
      vecs[2].mask = 4'b1111; vecs[2].hp = {8'd4,  8'd2, 8'd10, 8'd5};
      vecs[2].fq   = {12'd250, 12'd500, 12'd100, 12'd200};
      vecs[3].mask = 4'b0100; vecs[3].hp = {8'd4,  8'd1, 8'd10, 8'd5};
      vecs[3].fq   = {12'd0,   12'd1000, 12'd0,  12'd0};
      vecs[4].mask = 4'b1001; vecs[4].hp = {8'd25, 8'd2, 8'd10, 8'd20};
      vecs[4].fq   = {12'd40,  12'd0,   12'd0,   12'd50};

      reset = 1'b1; start = 1'b0; continuous = 1'b0; ch_mask = 4'b0000;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rv", 64'(rv), 64'd0);
      chk("rst_sd", 64'(sd), 64'd0);
      chk("rst_ch", 64'(rch), 64'd0);
      chk("rst_freq", 64'(rfreq), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      // Constant vectors: periods divide the gate, so counts are phase independent.
      for (int v = 0; v < 5; v++) begin
         for (int c = 0; c < 4; c++) hp[c] = int'(vecs[v].hp[c]);
         repeat (6) @(negedge clk);
         got_q.delete();
         ch_mask = vecs[v].mask;
         pulse_start(k);
         wait_idle(5 * (G + 3) + 20, "tbl");
         n = $countones(vecs[v].mask);
         chk($sformatf("tbl%0d_nres", v), 64'(got_q.size()), 64'(n));
         idx = 0;
         lastfq = 0;
         for (int c = 0; c < 4; c++) begin
            if (vecs[v].mask[c]) begin
               if (idx < got_q.size()) begin
                  chk($sformatf("tbl%0d_cyc%0d", v, idx), 64'(got_q[idx].cy), 64'(k + 4 + G + idx * (G + 3)));
                  chk($sformatf("tbl%0d_ch%0d", v, idx), 64'(got_q[idx].ch), 64'(c));
                  chk($sformatf("tbl%0d_freq%0d", v, idx), 64'(got_q[idx].fq), 64'(vecs[v].fq[c]));
                  chk($sformatf("tbl%0d_done%0d", v, idx), 64'(got_q[idx].dn), 64'(idx == n - 1));
               end
               lastfq = int'(vecs[v].fq[c]);
               idx++;
            end
         end
         chk($sformatf("tbl%0d_hold_freq", v), 64'(rfreq), 64'(lastfq));
         chk($sformatf("tbl%0d_hold_rv", v), 64'(rv), 64'd0);
         got_q.delete();
      end

      // Empty mask: neither start nor continuous may launch a sweep.
      got_q.delete();
      ch_mask = 4'b0000;
      pulse_start(k);
      continuous = 1'b1;
      seen = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (busy !== 1'b0) seen = 1'b1;
      end
      continuous = 1'b0;
      chk("nomask_busy", 64'(seen), 64'd0);
      chk("nomask_nres", 64'(got_q.size()), 64'd0);

      // Start and mask change while busy must not alter the running sweep.
      hp[0] = 3; hp[1] = 7;
      repeat (6) @(negedge clk);
      got_q.delete();
      ch_mask = 4'b0011;
      pulse_start(k);
      repeat (300) @(negedge clk);
      ch_mask = 4'b1111;
      pulse_start(k2);
      wait_idle(3 * (G + 3), "mid");
      model_sweep(k + 1, 4'b0011, ns);
      compare_q("midstart");

      // Reset in gate cycle 500 discards the measurement.
      hp[0] = 6;
      ch_mask = 4'b0001;
      repeat (6) @(negedge clk);
      got_q.delete();
      pulse_start(k);
      while (cyc < k + 502) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_rv", 64'(rv), 64'd0);
      chk("midrst_sd", 64'(sd), 64'd0);
      chk("midrst_ch", 64'(rch), 64'd0);
      chk("midrst_freq", 64'(rfreq), 64'd0);
      reset = 1'b0;
      repeat (1100) @(negedge clk);
      chk("midrst_nres", 64'(got_q.size()), 64'd0);
      pulse_start(k);
      wait_idle(2 * (G + 3), "postrst");
      model_sweep(k + 1, 4'b0001, ns);
      compare_q("postrst");

      // Continuous mode: two back-to-back sweeps over ch0/ch1, busy held throughout.
      hp[0] = $urandom_range(1, 30);
      hp[1] = $urandom_range(1, 30);
      ch_mask = 4'b0011;
      repeat (6) @(negedge clk);
      got_q.delete();
      k = cyc;
      continuous = 1'b1;
      dropped = 1'b0;
      n = 0;
      @(negedge clk);
      while (got_q.size() < 3 && n < 4 * (G + 3) + 50) begin
         if (busy !== 1'b1) dropped = 1'b1;
         @(negedge clk);
         n++;
      end
      continuous = 1'b0;
      wait_idle(3 * (G + 3), "cont");
      chk("cont_busy_dropped", 64'(dropped), 64'd0);
      model_sweep(k + 1, 4'b0011, s2);
      model_sweep(s2, 4'b0011, s3);
      compare_q("cont");

      // Random periods and masks against the reference model.
      for (int it = 0; it < 6; it++) begin
         for (int c = 0; c < 4; c++) hp[c] = $urandom_range(1, 30);
         m = 4'($urandom_range(1, 15));
         repeat ($urandom_range(6, 14)) @(negedge clk);
         got_q.delete();
         ch_mask = m;
         pulse_start(k);
         wait_idle(5 * (G + 3) + 20, "rnd");
         model_sweep(k + 1, m, ns);
         compare_q($sformatf("rnd%0d", it));
      end

      // Saturation on the narrow-counter instance: 20 edges into a 4-bit counter.
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      hp[0] = 1;
      ch_mask = 4'b0001;
      repeat (6) @(negedge clk);
      pulse_start(k);
      wait_rv2(100);
      chk("sat_cyc", 64'(cyc), 64'(k + 4 + G2));
      chk("sat_freq", 64'(rfreq2), 64'd30);
      chk("sat_ch", 64'(rch2), 64'd0);
      chk("sat_done", 64'(sd2), 64'd1);
`ifdef FREQ_SCHED_OVF_EN
      chk("sat_ovf", 64'(ovf2), 64'd1);
`endif
      hp[0] = 10;
      repeat (8) @(negedge clk);
      pulse_start(k);
      wait_rv2(100);
      chk("nosat_cyc", 64'(cyc), 64'(k + 4 + G2));
      chk("nosat_freq", 64'(rfreq2), 64'd4);
`ifdef FREQ_SCHED_OVF_EN
      chk("nosat_ovf", 64'(ovf2), 64'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
